// File: rtl/vmem_stride_agen_pkg.sv
// Shared vector-memory definitions: address-generator state encoding and the
// element-count / element-size defaults that the memory unit also uses.
package vmem_stride_agen_pkg;

  localparam int VMEM_LOG2MVL   = 6;
  localparam int VMEM_ELEMBYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GEN   = 2'd3
  } agen_state_t;

endpackage

// File: rtl/vmem_stride_agen.sv
// Strided element-address generator: reads one stride register, then emits
// base + i*stride for i = 0..vl-1. Optional unit-stride path: VSTRIDE_AGEN_UNIT_EN.
module vmem_stride_agen
  import vmem_stride_agen_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int LOG2NUMREGS = 3,
  parameter int LOG2MVL     = VMEM_LOG2MVL,
  parameter int ELEMBYTES   = VMEM_ELEMBYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   start_ready,
  input  logic [WIDTH-1:0]       start_base,
  input  logic [LOG2NUMREGS-1:0] start_sreg,
  input  logic [LOG2MVL:0]       start_vl,
`ifdef VSTRIDE_AGEN_UNIT_EN
  input  logic                   start_unit,
`endif
  output logic [LOG2NUMREGS-1:0] stride_reg,
  output logic                   stride_en,
  input  logic [WIDTH-1:0]       stride_data,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic [WIDTH-1:0]       addr,
  output logic [LOG2MVL-1:0]     addr_idx,
  output logic                   addr_last,
  output logic                   done
);

  localparam logic [LOG2MVL-1:0] IDX_ONE = LOG2MVL'(1);
  localparam logic [LOG2MVL:0]   VL_ONE  = (LOG2MVL + 1)'(1);
  localparam logic [WIDTH-1:0]   UNIT_STRIDE = WIDTH'(ELEMBYTES);

  agen_state_t            state_q;
  logic [WIDTH-1:0]       base_q;
  logic [LOG2NUMREGS-1:0] sreg_q;
  logic [LOG2MVL-1:0]     vl_m1_q;
  logic [WIDTH-1:0]       stride_q;
  logic [WIDTH-1:0]       acc_q;
  logic [LOG2MVL-1:0]     idx_q;
  logic                   zero_done_q;

  logic [WIDTH-1:0]       acc_d;
  logic [LOG2MVL-1:0]     idx_d;
  logic [LOG2MVL-1:0]     vl_m1_d;
  logic                   is_last;
  logic                   unit_cmd;

`ifdef VSTRIDE_AGEN_UNIT_EN
  assign unit_cmd = start_unit;
`else
  assign unit_cmd = 1'b0;
`endif

  always_comb begin
    acc_d   = acc_q + stride_q;
    idx_d   = idx_q + IDX_ONE;
    vl_m1_d = LOG2MVL'(start_vl - VL_ONE);
    is_last = (state_q == ST_GEN) && (idx_q == vl_m1_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      sreg_q      <= '0;
      vl_m1_q     <= '0;
      stride_q    <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q  <= start_base;
            sreg_q  <= start_sreg;
            vl_m1_q <= vl_m1_d;
            if (start_vl == '0) begin
              // Empty vector: complete without touching the regfile.
              zero_done_q <= 1'b1;
            end else if (unit_cmd) begin
              stride_q <= UNIT_STRIDE;
              acc_q    <= start_base;
              idx_q    <= '0;
              state_q  <= ST_GEN;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FETCH: state_q <= ST_WAIT;
        ST_WAIT: begin
          // Regfile data arrives the cycle after the read enable.
          stride_q <= stride_data;
          acc_q    <= base_q;
          idx_q    <= '0;
          state_q  <= ST_GEN;
        end
        ST_GEN: begin
          if (addr_ready) begin
            if (is_last) begin
              state_q <= ST_IDLE;
            end else begin
              acc_q <= acc_d;
              idx_q <= idx_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign stride_en   = (state_q == ST_FETCH);
  assign stride_reg  = (state_q == ST_FETCH) ? sreg_q : '0;
  assign addr_valid  = (state_q == ST_GEN);
  assign addr        = acc_q;
  assign addr_idx    = idx_q;
  assign addr_last   = is_last;
  assign done        = zero_done_q | (is_last & addr_ready);

endmodule
